sdram_test_gen: RTL

SDRAM_TEST_GEN -- requirements
Module: sdram_test_gen

---
 rtl/sdram_pkg.sv | 25 ++
 rtl/sdram_test_gen_if.sv | 27 ++
 rtl/sdram_test_chk.sv | 38 +++
 rtl/sdram_test_gen.sv | 117 +++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM pattern test generator: data width, FSM state
// encoding and the pattern-word helper used by the write and compare paths.
package sdram_pkg;

  localparam int DATA_W  = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_PREFILL = 3'd4,
    ST_READ    = 3'd5,
    ST_CHECK   = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  // Pattern word k of a pass; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] pattern_word(input logic [DATA_W-1:0] base,
                                                     input logic [DATA_W-1:0] k);
    return base + k;
  endfunction

endpackage

// File: rtl/sdram_test_gen_if.sv
// User-side FIFO port bundle between the test generator (master) and the
// SDRAM FIFO controller (slave).
interface sdram_test_gen_if;
  import sdram_pkg::*;

  // Handshake: wr_en/rd_en are single-cycle strobes with no backpressure, one
  // word per cycle; rd_data is valid the cycle after each rd_en. wr_load and
  // rd_load reset the FIFOs/addresses; sdram_read_valid is a level enable.
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_load;
  logic              rd_load;
  logic              sdram_read_valid;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_en, wr_data, wr_load, rd_load, sdram_read_valid, rd_en,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_data, wr_load, rd_load, sdram_read_valid, rd_en,
    output rd_data
  );

endinterface

// File: rtl/sdram_test_chk.sv
// Readback comparator: sticky error flag plus a saturating mismatch counter.
module sdram_test_chk
  import sdram_pkg::*;
(
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              cmp_en_i,
  input  logic [DATA_W-1:0] act_i,
  input  logic [DATA_W-1:0] exp_i,
  output logic              error_flag_o,
  output logic [DATA_W-1:0] err_cnt_o
);

  logic              err_q, err_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              mismatch;

  always_comb begin
    mismatch = cmp_en_i && (act_i != exp_i);
    err_d    = err_q | mismatch;
    cnt_d    = cnt_q;
    if (mismatch && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign error_flag_o = err_q;
  assign err_cnt_o    = cnt_q;

endmodule

// File: rtl/sdram_test_gen.sv
// SDRAM write/readback pattern generator. Define SDRAM_TEST_LOOP_EN to loop
// passes forever (DONE -> LOAD) and expose the pass_cnt output.
module sdram_test_gen
  import sdram_pkg::*;
#(
  parameter int                TEST_LEN       = 1024,
  parameter logic [DATA_W-1:0] DATA_BASE      = 16'd1,
  parameter int                DRAIN_CYCLES   = 512,
  parameter int                PREFILL_CYCLES = 64,
  parameter int                LOAD_CYCLES    = 4
) (
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  sdram_test_gen_if.master  bus,
  output logic              done,
  output logic              error_flag,
  output logic [DATA_W-1:0] err_cnt,
`ifdef SDRAM_TEST_LOOP_EN
  output logic [DATA_W-1:0] pass_cnt,
`endif
  output state_e            dbg_state_o
);

  localparam logic [31:0] LOAD_LAST    = 32'(LOAD_CYCLES - 1);
  localparam logic [31:0] LEN_LAST     = 32'(TEST_LEN - 1);
  localparam logic [31:0] DRAIN_LAST   = 32'(DRAIN_CYCLES - 1);
  localparam logic [31:0] PREFILL_LAST = 32'(PREFILL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] exp_k_q, exp_k_d;
  logic              rvalid_q, rvalid_d;
  logic              cmp_en_q;
  logic              abort;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      exp_k_q  <= '0;
      rvalid_q <= 1'b0;
      cmp_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exp_k_q  <= exp_k_d;
      rvalid_q <= rvalid_d;
      cmp_en_q <= (state_q == ST_READ);
    end
  end

  always_comb begin
    state_d  = state_q;
    rvalid_d = rvalid_q;
    exp_k_d  = cmp_en_q ? exp_k_q + 16'd1 : exp_k_q;
    abort    = !sdram_init_done && (state_q != ST_IDLE) && (state_q != ST_DONE);

    unique case (state_q)
      ST_IDLE:    if (sdram_init_done) state_d = ST_LOAD;
      ST_LOAD:    if (cnt_q == LOAD_LAST) state_d = ST_WRITE;
      ST_WRITE:   if (cnt_q == LEN_LAST) state_d = ST_DRAIN;
      ST_DRAIN:   if (cnt_q == DRAIN_LAST) state_d = ST_PREFILL;
      ST_PREFILL: if (cnt_q == PREFILL_LAST) state_d = ST_READ;
      ST_READ:    if (cnt_q == LEN_LAST) state_d = ST_CHECK;
      ST_CHECK:   state_d = ST_DONE;
`ifdef SDRAM_TEST_LOOP_EN
      ST_DONE:    state_d = ST_LOAD;
`else
      ST_DONE:    state_d = ST_DONE;
`endif
      default:    state_d = ST_IDLE;
    endcase

    if (abort) state_d = ST_IDLE;

    // One shared counter: restarts on every state change, so it doubles as k.
    cnt_d = (state_d == state_q) ? cnt_q + 32'd1 : '0;

    if (state_d == ST_PREFILL) rvalid_d = 1'b1;
    if (state_d == ST_LOAD) begin
      rvalid_d = 1'b0;
      exp_k_d  = '0;
    end
  end

  assign bus.wr_en            = (state_q == ST_WRITE);
  assign bus.wr_data          = (state_q == ST_WRITE) ? pattern_word(DATA_BASE, cnt_q[DATA_W-1:0]) : '0;
  assign bus.wr_load          = (state_q == ST_LOAD);
  assign bus.rd_load          = (state_q == ST_LOAD);
  assign bus.sdram_read_valid = rvalid_q;
  assign bus.rd_en            = (state_q == ST_READ);
  assign done                 = (state_q == ST_DONE);
  assign dbg_state_o          = state_q;

  sdram_test_chk u_chk (
    .clk_ref      (clk_ref),
    .rst_n        (rst_n),
    .cmp_en_i     (cmp_en_q),
    .act_i        (bus.rd_data),
    .exp_i        (pattern_word(DATA_BASE, exp_k_q)),
    .error_flag_o (error_flag),
    .err_cnt_o    (err_cnt)
  );

`ifdef SDRAM_TEST_LOOP_EN
  logic [DATA_W-1:0] pass_cnt_q;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n)                 pass_cnt_q <= '0;
    else if (state_q == ST_DONE) pass_cnt_q <= pass_cnt_q + 16'd1;
  end

  assign pass_cnt = pass_cnt_q;
`endif

endmodule
